// File: rtl/mpsoc_wb_ext_arbiter.sv
// Round-robin arbiter sharing one external Wishbone slave port among tile masters.
// Grant is held for the whole bus cycle; a watchdog turns a stalled strobe into an error.
module mpsoc_wb_ext_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [NUM_MASTERS-1:0]     m_cyc_i,
  input  logic [NUM_MASTERS-1:0]     m_stb_i,
  input  logic [NUM_MASTERS-1:0]     m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]  m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]   m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]   m_bte_i,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_err_o,
  output logic [NUM_MASTERS-1:0]     m_rty_o,
  output logic [DW-1:0]              m_dat_o,

  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [AW-1:0]              s_adr_o,
  output logic [DW-1:0]              s_dat_o,
  output logic [DW/8-1:0]            s_sel_o,
  output logic [2:0]                 s_cti_o,
  output logic [1:0]                 s_bte_o,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic                       s_rty_i,
  input  logic [DW-1:0]              s_dat_i,

  output logic [NUM_MASTERS-1:0]     grant_o,
  output logic                       timeout_o
);

  // state | meaning
  // IDLE  | no owner; arbitrate among raised cyc lines
  // BUSY  | gnt_idx owns the slave port until its cyc drops

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gnt_idx, gnt_idx_nxt;
  logic [IW-1:0] last_grant, last_grant_nxt;
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic [IW-1:0] req_idx;
  logic          req_found;
  logic          busy, g_cyc, g_stb, resp_any, timeout_hit;

  assign busy     = (state == BUSY);
  assign g_cyc    = m_cyc_i[gnt_idx];
  assign g_stb    = m_stb_i[gnt_idx];
  assign resp_any = s_ack_i | s_err_i | s_rty_i;
  // A response on the terminal cycle wins over the forced error.
  assign timeout_hit = busy && g_cyc && g_stb && !resp_any && (wd_cnt == CW'(TIMEOUT));

  always_comb begin
    req_found = 1'b0;
    req_idx   = last_grant;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!req_found && m_cyc_i[(int'(last_grant) + i) % NUM_MASTERS]) begin
        req_found = 1'b1;
        req_idx   = IW'((int'(last_grant) + i) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_idx_nxt    = gnt_idx;
    last_grant_nxt = last_grant;
    wd_cnt_nxt     = '0;
    case (state)
      IDLE: begin
        if (req_found) begin
          state_nxt   = BUSY;
          gnt_idx_nxt = req_idx;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_nxt      = IDLE;
          last_grant_nxt = gnt_idx;
        end else if (g_stb && !resp_any && !timeout_hit) begin
          wd_cnt_nxt = wd_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt_idx    <= '0;
      last_grant <= IW'(NUM_MASTERS - 1);
      wd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      gnt_idx    <= gnt_idx_nxt;
      last_grant <= last_grant_nxt;
      wd_cnt     <= wd_cnt_nxt;
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    grant_o   = '0;
    timeout_o = timeout_hit;
    if (busy) begin
      s_cyc_o          = g_cyc & ~timeout_hit;
      s_stb_o          = g_stb & ~timeout_hit;
      s_we_o           = m_we_i[gnt_idx];
      s_adr_o          = m_adr_i[gnt_idx*AW +: AW];
      s_dat_o          = m_dat_i[gnt_idx*DW +: DW];
      s_sel_o          = m_sel_i[gnt_idx*SW +: SW];
      s_cti_o          = m_cti_i[gnt_idx*3 +: 3];
      s_bte_o          = m_bte_i[gnt_idx*2 +: 2];
      m_ack_o[gnt_idx] = s_ack_i;
      m_err_o[gnt_idx] = s_err_i | timeout_hit;
      m_rty_o[gnt_idx] = s_rty_i;
      grant_o[gnt_idx] = 1'b1;
    end
  end

  assign m_dat_o = s_dat_i;

endmodule
